// File: rtl/usb_buf_pkg.sv
// Shared types and constants for the endpoint data buffer controller.
package usb_buf_pkg;

    localparam int BUF_DEPTH  = 64;
    localparam int OCC_W      = 7;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_FILL = 3'd1,
        TX_SEND = 3'd2,
        RX_RECV = 3'd3,
        RX_READ = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/data_buffer_ctrl_if.sv
// Handshake and buffer-strobe bundle between requesters, controller and buffer.
// The master side is the requester/buffer environment, the slave side is the controller.
interface data_buffer_ctrl_if;
    import usb_buf_pkg::*;

    // requester handshakes
    logic                  ahb_wr_req;
    logic [DATA_WIDTH-1:0] ahb_wdata;
    logic                  ahb_rd_req;
    logic                  ahb_clear_req;
    logic                  tx_start;
    logic                  usb_rd_req;
    logic                  usb_wr_req;
    logic [DATA_WIDTH-1:0] usb_wdata;
    logic                  usb_rx_done;
    logic                  usb_rx_error;
    logic [OCC_W-1:0]      buffer_occupancy;

    // buffer strobes and data
    logic                  clear;
    logic                  flush;
    logic                  store_tx_data;
    logic                  get_tx_packet_data;
    logic                  store_rx_packet_data;
    logic                  get_rx_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_packet_data;

    // grants and status
    logic                  ahb_wr_ack;
    logic                  ahb_rd_ack;
    logic                  usb_wr_ack;
    logic                  usb_rd_ack;
    logic                  tx_data_ready;
    logic                  rx_data_ready;
    logic                  overrun;
    logic                  conflict;
    logic [2:0]            ctrl_state;

    modport master (
        output ahb_wr_req, ahb_wdata, ahb_rd_req, ahb_clear_req, tx_start,
               usb_rd_req, usb_wr_req, usb_wdata, usb_rx_done, usb_rx_error,
               buffer_occupancy,
        input  clear, flush, store_tx_data, get_tx_packet_data,
               store_rx_packet_data, get_rx_data, tx_data, rx_packet_data,
               ahb_wr_ack, ahb_rd_ack, usb_wr_ack, usb_rd_ack,
               tx_data_ready, rx_data_ready, overrun, conflict, ctrl_state
    );

    modport slave (
        input  ahb_wr_req, ahb_wdata, ahb_rd_req, ahb_clear_req, tx_start,
               usb_rd_req, usb_wr_req, usb_wdata, usb_rx_done, usb_rx_error,
               buffer_occupancy,
        output clear, flush, store_tx_data, get_tx_packet_data,
               store_rx_packet_data, get_rx_data, tx_data, rx_packet_data,
               ahb_wr_ack, ahb_rd_ack, usb_wr_ack, usb_rd_ack,
               tx_data_ready, rx_data_ready, overrun, conflict, ctrl_state
    );

endinterface

// File: rtl/data_buffer_ctrl.sv
// Sequencer/arbiter for the shared 64-byte endpoint buffer. Converts requester
// handshakes into single-cycle buffer strobes one clock after the request and
// blocks overflow, underflow and wrong-direction accesses.
module data_buffer_ctrl
    import usb_buf_pkg::*;
#(
    parameter int DATA_WIDTH = usb_buf_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = usb_buf_pkg::BUF_DEPTH
) (
    input logic           clk,
    input logic           rst,
    data_buffer_ctrl_if.slave bus
);

    // One extra bit so the pending-store correction cannot wrap.
    localparam logic [OCC_W:0] LP_DEPTH = BUF_DEPTH[OCC_W:0];

    ctrl_state_t           r_state;
    ctrl_state_t           w_state_nxt;

    logic                  r_clear,     w_clear_nxt;
    logic                  r_flush,     w_flush_nxt;
    logic                  r_store_tx,  w_store_tx_nxt;
    logic                  r_get_tx,    w_get_tx_nxt;
    logic                  r_store_rx,  w_store_rx_nxt;
    logic                  r_get_rx,    w_get_rx_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data,   w_tx_data_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data,   w_rx_data_nxt;
    logic                  r_tx_ready,  w_tx_ready_nxt;
    logic                  r_rx_ready,  w_rx_ready_nxt;
    logic                  r_overrun,   w_overrun_nxt;
    logic                  r_conflict,  w_conflict_nxt;

    logic                  w_store_pend;
    logic                  w_get_pend;
    logic [OCC_W:0]        w_occ_eff;
    logic                  w_room;
    logic                  w_avail;
    logic                  w_last;

    // The strobes currently on the bus have not reached buffer_occupancy yet,
    // so fold them in before any full/empty decision.
    assign w_store_pend = r_store_tx | r_store_rx;
    assign w_get_pend   = r_get_tx | r_get_rx;
    assign w_occ_eff    = {1'b0, bus.buffer_occupancy}
                        + {{OCC_W{1'b0}}, w_store_pend}
                        - {{OCC_W{1'b0}}, w_get_pend};
    assign w_room       = (w_occ_eff < LP_DEPTH);
    assign w_avail      = (w_occ_eff != {(OCC_W+1){1'b0}});
    assign w_last       = (w_occ_eff == {{OCC_W{1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, strobe, grant and flag decisions for the coming cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_clear_nxt    = 1'b0;
        w_flush_nxt    = 1'b0;
        w_store_tx_nxt = 1'b0;
        w_get_tx_nxt   = 1'b0;
        w_store_rx_nxt = 1'b0;
        w_get_rx_nxt   = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_rx_data_nxt  = r_rx_data;
        w_tx_ready_nxt = r_tx_ready;
        w_rx_ready_nxt = r_rx_ready;
        w_overrun_nxt  = r_overrun;
        w_conflict_nxt = r_conflict;

        if (bus.ahb_clear_req) begin
            // Clear overrides everything, including requests in the same cycle.
            w_clear_nxt    = 1'b1;
            w_state_nxt    = IDLE;
            w_tx_ready_nxt = 1'b0;
            w_rx_ready_nxt = 1'b0;
            w_overrun_nxt  = 1'b0;
            w_conflict_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // USB receive wins a same-cycle tie with an AHB write.
                    if (bus.usb_wr_req) begin
                        w_store_rx_nxt = 1'b1;
                        w_rx_data_nxt  = bus.usb_wdata;
                        w_state_nxt    = RX_RECV;
                    end else if (bus.ahb_wr_req) begin
                        w_store_tx_nxt = 1'b1;
                        w_tx_data_nxt  = bus.ahb_wdata;
                        w_state_nxt    = TX_FILL;
                    end else begin
                        w_state_nxt    = IDLE;
                    end
                end

                TX_FILL: begin
                    if (bus.ahb_wr_req && w_room) begin
                        w_store_tx_nxt = 1'b1;
                        w_tx_data_nxt  = bus.ahb_wdata;
                    end else if (bus.ahb_wr_req) begin
                        w_overrun_nxt  = 1'b1;
                    end else begin
                        w_store_tx_nxt = 1'b0;
                    end
                    if (bus.tx_start) begin
                        w_state_nxt    = TX_SEND;
                        w_tx_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = TX_FILL;
                    end
                    if (bus.usb_wr_req || bus.usb_rd_req || bus.ahb_rd_req) begin
                        w_conflict_nxt = 1'b1;
                    end else begin
                        w_conflict_nxt = r_conflict;
                    end
                end

                TX_SEND: begin
                    if (bus.usb_rd_req && w_avail) begin
                        w_get_tx_nxt = 1'b1;
                        if (w_last) begin
                            w_state_nxt    = IDLE;
                            w_tx_ready_nxt = 1'b0;
                        end else begin
                            w_state_nxt    = TX_SEND;
                        end
                    end else begin
                        w_get_tx_nxt = 1'b0;
                    end
                    if (bus.ahb_wr_req || bus.usb_wr_req || bus.ahb_rd_req) begin
                        w_conflict_nxt = 1'b1;
                    end else begin
                        w_conflict_nxt = r_conflict;
                    end
                end

                RX_RECV: begin
                    if (bus.usb_rx_error) begin
                        // A bad packet is discarded; pending byte is dropped too.
                        w_flush_nxt    = 1'b1;
                        w_state_nxt    = IDLE;
                        w_rx_ready_nxt = 1'b0;
                    end else begin
                        if (bus.usb_wr_req && w_room) begin
                            w_store_rx_nxt = 1'b1;
                            w_rx_data_nxt  = bus.usb_wdata;
                        end else if (bus.usb_wr_req) begin
                            w_overrun_nxt  = 1'b1;
                        end else begin
                            w_store_rx_nxt = 1'b0;
                        end
                        if (bus.usb_rx_done) begin
                            // A byte granted alongside done still counts as data.
                            if (w_avail || (bus.usb_wr_req && w_room)) begin
                                w_state_nxt    = RX_READ;
                                w_rx_ready_nxt = 1'b1;
                            end else begin
                                w_state_nxt    = IDLE;
                            end
                        end else begin
                            w_state_nxt = RX_RECV;
                        end
                    end
                    if (bus.ahb_wr_req || bus.ahb_rd_req || bus.usb_rd_req) begin
                        w_conflict_nxt = 1'b1;
                    end else begin
                        w_conflict_nxt = r_conflict;
                    end
                end

                RX_READ: begin
                    if (bus.ahb_rd_req && w_avail) begin
                        w_get_rx_nxt = 1'b1;
                        if (w_last) begin
                            w_state_nxt    = IDLE;
                            w_rx_ready_nxt = 1'b0;
                        end else begin
                            w_state_nxt    = RX_READ;
                        end
                    end else begin
                        w_get_rx_nxt = 1'b0;
                    end
                    if (bus.ahb_wr_req || bus.usb_wr_req || bus.usb_rd_req) begin
                        w_conflict_nxt = 1'b1;
                    end else begin
                        w_conflict_nxt = r_conflict;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered strobes, data and flags; everything returns to zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clear    <= 1'b0;
            r_flush    <= 1'b0;
            r_store_tx <= 1'b0;
            r_get_tx   <= 1'b0;
            r_store_rx <= 1'b0;
            r_get_rx   <= 1'b0;
            r_tx_data  <= {DATA_WIDTH{1'b0}};
            r_rx_data  <= {DATA_WIDTH{1'b0}};
            r_tx_ready <= 1'b0;
            r_rx_ready <= 1'b0;
            r_overrun  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_clear    <= w_clear_nxt;
            r_flush    <= w_flush_nxt;
            r_store_tx <= w_store_tx_nxt;
            r_get_tx   <= w_get_tx_nxt;
            r_store_rx <= w_store_rx_nxt;
            r_get_rx   <= w_get_rx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_overrun  <= w_overrun_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    // Each grant coincides with the strobe it authorises.
    assign bus.clear                = r_clear;
    assign bus.flush                = r_flush;
    assign bus.store_tx_data        = r_store_tx;
    assign bus.get_tx_packet_data   = r_get_tx;
    assign bus.store_rx_packet_data = r_store_rx;
    assign bus.get_rx_data          = r_get_rx;
    assign bus.tx_data              = r_tx_data;
    assign bus.rx_packet_data       = r_rx_data;
    assign bus.ahb_wr_ack           = r_store_tx;
    assign bus.ahb_rd_ack           = r_get_rx;
    assign bus.usb_wr_ack           = r_store_rx;
    assign bus.usb_rd_ack           = r_get_tx;
    assign bus.tx_data_ready        = r_tx_ready;
    assign bus.rx_data_ready        = r_rx_ready;
    assign bus.overrun              = r_overrun;
    assign bus.conflict             = r_conflict;
    assign bus.ctrl_state           = r_state;

endmodule

// File: tb/tb_data_buffer_ctrl.sv
// Directed self-checking bench for data_buffer_ctrl with a simple buffer
// occupancy model standing in for the real 64-byte buffer.
module tb_data_buffer_ctrl;

    logic       clk;
    logic       rst;
    int         n_total;
    int         n_bad;
    int         ack_cnt;
    logic       last_ack;
    logic [6:0] r_occ_model;

    data_buffer_ctrl_if u_bus ();

    data_buffer_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer occupancy model driven by the controller's strobes.
    always @(posedge clk) begin
        if (rst || u_bus.clear || u_bus.flush) begin
            r_occ_model <= 7'd0;
        end else begin
            r_occ_model <= r_occ_model + {6'd0, (u_bus.store_tx_data | u_bus.store_rx_packet_data)}
                                       - {6'd0, (u_bus.get_tx_packet_data | u_bus.get_rx_data)};
        end
    end
    assign u_bus.buffer_occupancy = r_occ_model;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clear"}, {31'd0, u_bus.clear}, 32'd0);
        chk({tag, "_flush"}, {31'd0, u_bus.flush}, 32'd0);
        chk({tag, "_strobes"}, {28'd0, u_bus.store_tx_data, u_bus.get_tx_packet_data,
                                u_bus.store_rx_packet_data, u_bus.get_rx_data}, 32'd0);
        chk({tag, "_acks"}, {28'd0, u_bus.ahb_wr_ack, u_bus.ahb_rd_ack,
                             u_bus.usb_wr_ack, u_bus.usb_rd_ack}, 32'd0);
        chk({tag, "_data"}, {16'd0, u_bus.tx_data, u_bus.rx_packet_data}, 32'd0);
        chk({tag, "_flags"}, {28'd0, u_bus.tx_data_ready, u_bus.rx_data_ready,
                              u_bus.overrun, u_bus.conflict}, 32'd0);
        chk({tag, "_state"}, {29'd0, u_bus.ctrl_state}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        u_bus.ahb_wr_req    = 1'b0;
        u_bus.ahb_wdata     = 8'h00;
        u_bus.ahb_rd_req    = 1'b0;
        u_bus.ahb_clear_req = 1'b0;
        u_bus.tx_start      = 1'b0;
        u_bus.usb_rd_req    = 1'b0;
        u_bus.usb_wr_req    = 1'b0;
        u_bus.usb_wdata     = 8'h00;
        u_bus.usb_rx_done   = 1'b0;
        u_bus.usb_rx_error  = 1'b0;

        // Reset: two clocks, then one idle clock after release.
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        chk_all_zero("post_rst");

        // TX fill with 0xA0..0xA3.
        for (int i = 0; i < 4; i++) begin
            u_bus.ahb_wr_req = 1'b1;
            u_bus.ahb_wdata  = 8'hA0 + 8'(i);
            tick();
            chk("tx_store", {31'd0, u_bus.store_tx_data}, 32'd1);
            chk("tx_wr_ack", {31'd0, u_bus.ahb_wr_ack}, 32'd1);
            chk("tx_data", {24'd0, u_bus.tx_data}, 32'hA0 + 32'(i));
            chk("tx_fill_state", {29'd0, u_bus.ctrl_state}, 32'd1);
        end
        u_bus.ahb_wr_req = 1'b0;
        u_bus.tx_start   = 1'b1;
        tick();
        u_bus.tx_start   = 1'b0;
        chk("tx_ready_set", {31'd0, u_bus.tx_data_ready}, 32'd1);
        chk("tx_send_state", {29'd0, u_bus.ctrl_state}, 32'd2);
        chk("tx_no_store", {31'd0, u_bus.store_tx_data}, 32'd0);

        // TX drain: four back-to-back reads, last one returns to IDLE.
        u_bus.usb_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tx_get", {31'd0, u_bus.get_tx_packet_data}, 32'd1);
            chk("tx_rd_ack", {31'd0, u_bus.usb_rd_ack}, 32'd1);
            chk("tx_drain_state", {29'd0, u_bus.ctrl_state}, (i == 3) ? 32'd0 : 32'd2);
        end
        u_bus.usb_rd_req = 1'b0;
        chk("tx_ready_clr", {31'd0, u_bus.tx_data_ready}, 32'd0);
        tick();
        chk("tx_get_done", {31'd0, u_bus.get_tx_packet_data}, 32'd0);
        chk("tx_occ_empty", {25'd0, r_occ_model}, 32'd0);

        // RX overrun: 65 bytes streamed, only 64 granted.
        ack_cnt  = 0;
        last_ack = 1'b0;
        u_bus.usb_wr_req = 1'b1;
        for (int i = 0; i < 65; i++) begin
            u_bus.usb_wdata = 8'(i + 1);
            tick();
            if (u_bus.usb_wr_ack) ack_cnt++;
            last_ack = u_bus.usb_wr_ack;
            if (i == 0) chk("rx_first_data", {24'd0, u_bus.rx_packet_data}, 32'd1);
            if (i == 63) chk("rx_64th_data", {24'd0, u_bus.rx_packet_data}, 32'd64);
        end
        u_bus.usb_wr_req = 1'b0;
        chk("ovr_ack_count", ack_cnt, 32'd64);
        chk("ovr_65th_ack", {31'd0, last_ack}, 32'd0);
        chk("ovr_flag", {31'd0, u_bus.overrun}, 32'd1);
        chk("ovr_state", {29'd0, u_bus.ctrl_state}, 32'd3);

        // Clear out of the full RX buffer.
        u_bus.ahb_clear_req = 1'b1;
        tick();
        u_bus.ahb_clear_req = 1'b0;
        chk("clr1_pulse", {31'd0, u_bus.clear}, 32'd1);
        chk("clr1_overrun", {31'd0, u_bus.overrun}, 32'd0);
        chk("clr1_state", {29'd0, u_bus.ctrl_state}, 32'd0);
        tick();
        chk("clr1_once", {31'd0, u_bus.clear}, 32'd0);

        // RX error: 10 bytes, then error together with another write.
        u_bus.usb_wr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_bus.usb_wdata = 8'h30 + 8'(i);
            tick();
        end
        chk("err_pre_ack", {31'd0, u_bus.usb_wr_ack}, 32'd1);
        u_bus.usb_rx_error = 1'b1;
        tick();
        u_bus.usb_rx_error = 1'b0;
        u_bus.usb_wr_req   = 1'b0;
        chk("err_flush", {31'd0, u_bus.flush}, 32'd1);
        chk("err_no_ack", {31'd0, u_bus.usb_wr_ack}, 32'd0);
        chk("err_state", {29'd0, u_bus.ctrl_state}, 32'd0);
        tick();
        chk("err_flush_once", {31'd0, u_bus.flush}, 32'd0);

        // Conflict: reach RX_READ with 3 bytes, read one, then an AHB write.
        u_bus.usb_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_bus.usb_wdata = 8'h50 + 8'(i);
            tick();
        end
        u_bus.usb_wr_req  = 1'b0;
        u_bus.usb_rx_done = 1'b1;
        tick();
        u_bus.usb_rx_done = 1'b0;
        chk("rd_state", {29'd0, u_bus.ctrl_state}, 32'd4);
        chk("rd_ready", {31'd0, u_bus.rx_data_ready}, 32'd1);
        u_bus.ahb_rd_req = 1'b1;
        tick();
        u_bus.ahb_rd_req = 1'b0;
        chk("rd_get", {31'd0, u_bus.get_rx_data}, 32'd1);
        chk("rd_ack", {31'd0, u_bus.ahb_rd_ack}, 32'd1);
        u_bus.ahb_wr_req = 1'b1;
        u_bus.ahb_wdata  = 8'h77;
        tick();
        u_bus.ahb_wr_req = 1'b0;
        chk("cfl_no_ack", {31'd0, u_bus.ahb_wr_ack}, 32'd0);
        chk("cfl_no_store", {31'd0, u_bus.store_tx_data}, 32'd0);
        chk("cfl_flag", {31'd0, u_bus.conflict}, 32'd1);
        chk("cfl_state", {29'd0, u_bus.ctrl_state}, 32'd4);
        u_bus.ahb_clear_req = 1'b1;
        tick();
        u_bus.ahb_clear_req = 1'b0;
        chk("clr2_pulse", {31'd0, u_bus.clear}, 32'd1);
        chk("clr2_flags", {30'd0, u_bus.overrun, u_bus.conflict}, 32'd0);
        chk("clr2_ready", {31'd0, u_bus.rx_data_ready}, 32'd0);
        chk("clr2_state", {29'd0, u_bus.ctrl_state}, 32'd0);
        tick();

        // Same-cycle AHB/USB write from IDLE: USB wins.
        u_bus.ahb_wr_req = 1'b1;
        u_bus.ahb_wdata  = 8'h11;
        u_bus.usb_wr_req = 1'b1;
        u_bus.usb_wdata  = 8'h22;
        tick();
        u_bus.ahb_wr_req = 1'b0;
        u_bus.usb_wr_req = 1'b0;
        chk("arb_usb_ack", {31'd0, u_bus.usb_wr_ack}, 32'd1);
        chk("arb_ahb_ack", {31'd0, u_bus.ahb_wr_ack}, 32'd0);
        chk("arb_rx_data", {24'd0, u_bus.rx_packet_data}, 32'h22);
        chk("arb_state", {29'd0, u_bus.ctrl_state}, 32'd3);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_buffer_ctrl.md
# data_buffer_ctrl

Sequencer and arbiter for the shared 64-byte endpoint data buffer. It sits between the AHB slave interface and the USB RX/TX protocol engines and decides which side owns the buffer. It turns requester handshakes into the buffer's single-cycle strobes: `store_tx_data`, `get_tx_packet_data`, `store_rx_packet_data`, `get_rx_data`, `clear` and `flush`. It also stops overflow, underflow and direction conflicts before they reach the buffer.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width of buffer data.
- `BUF_DEPTH`, 64, buffer capacity in bytes. Occupancy width is 7.

Ports:
- `clk` in, 1: system clock, rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `ahb_wr_req` in, 1: AHB wants to write one TX byte.
- `ahb_wdata` in, 8: TX byte from AHB.
- `ahb_rd_req` in, 1: AHB wants to read one RX byte.
- `ahb_clear_req` in, 1: AHB buffer-clear command.
- `tx_start` in, 1: AHB marks the TX packet complete.
- `usb_rd_req` in, 1: TX engine wants the next packet byte.
- `usb_wr_req` in, 1: RX engine delivers one byte.
- `usb_wdata` in, 8: RX byte.
- `usb_rx_done` in, 1: RX packet ended with good CRC.
- `usb_rx_error` in, 1: RX packet aborted or bad.
- `buffer_occupancy` in, 7: buffer fill count.
- `clear`, `flush`, `store_tx_data`, `get_tx_packet_data`, `store_rx_packet_data`, `get_rx_data` out, 1: buffer strobes.
- `tx_data`, `rx_packet_data` out, 8: registered write data to the buffer.
- `ahb_wr_ack`, `ahb_rd_ack`, `usb_wr_ack`, `usb_rd_ack` out, 1: grant pulses.
- `tx_data_ready`, `rx_data_ready` out, 1: level status flags.
- `overrun`, `conflict` out, 1: sticky error flags.
- `ctrl_state` out, 3: current state encoding.

## Operation
States: `IDLE`, `TX_FILL`, `TX_SEND`, `RX_RECV`, `RX_READ`.

- **Effective occupancy.** `occ_eff = buffer_occupancy + store_pending - get_pending`, where the pending terms are the strobes issued last cycle. All full and empty decisions use `occ_eff`.
- **Clear.** `ahb_clear_req` in any state has the highest priority. It pulses `clear`, moves to `IDLE`, drops both ready flags and clears `overrun` and `conflict`. Any other request in that cycle is not acknowledged.
- **`IDLE`.**
  - `usb_wr_req` stores the byte and moves to `RX_RECV`.
  - Otherwise `ahb_wr_req` stores the byte and moves to `TX_FILL`.
  - If both arrive in the same cycle, USB wins and the AHB write gets no ack.
- **`TX_FILL`.**
  - `ahb_wr_req` with `occ_eff < 64` stores and acks. At 64 the write gets no ack and `overrun` is set.
  - `tx_start` moves to `TX_SEND` and sets `tx_data_ready`.
- **`TX_SEND`.**
  - `usb_rd_req` with `occ_eff > 0` pulses `get_tx_packet_data` and acks.
  - Granting the read when `occ_eff == 1` moves to `IDLE` and clears `tx_data_ready`.
- **`RX_RECV`.**
  - `usb_wr_req` with `occ_eff < 64` stores and acks. Otherwise it is dropped and `overrun` is set.
  - `usb_rx_error` pulses `flush` and moves to `IDLE`. It has priority over `usb_wr_req` and `usb_rx_done` in the same cycle.
  - `usb_rx_done` moves to `RX_READ` and sets `rx_data_ready` if `occ_eff > 0`. If `occ_eff == 0` it moves to `IDLE`.
- **`RX_READ`.**
  - `ahb_rd_req` with `occ_eff > 0` pulses `get_rx_data` and acks.
  - The last byte moves to `IDLE` and clears `rx_data_ready`.
- **Wrong-direction requests.** Any request invalid for the current state (AHB write during RX, USB write during TX, and so on) gets no ack and sets `conflict`.
- **Read underflow.** A read request when `occ_eff == 0` gets no ack and sets no flag.

## Timing
- Requests are sampled at the rising edge.
- The strobe, its ack and the data register are asserted together in the following cycle, for exactly one cycle. Latency is 1 clock.
- Back-to-back requests on consecutive cycles are granted every cycle. Throughput is 1 byte per clock.
- Requesters must hold a request until they see the ack or withdraw it. An un-acked request is re-evaluated every cycle.
- On `rst`, and in the cycle after it: every output is 0, `ctrl_state = IDLE`, the pending terms are 0, and the sticky flags are 0.
- Reset mid-transfer abandons the transfer. Buffer contents are the buffer's own concern; the controller issues no `clear`.

## Structure
- The shared package `usb_buf_pkg` holds:
  - `ctrl_state_t` enum: `IDLE=0`, `TX_FILL=1`, `TX_SEND=2`, `RX_RECV=3`, `RX_READ=4`.
  - Constants `BUF_DEPTH=64`, `OCC_W=7` and `DATA_WIDTH=8`.
- The block is a single module with no sub-module: a next-state block, a registered output block and the `occ_eff` adder.

## Test plan
- **Reset.** Assert `rst` for 2 clocks -> all outputs 0 and `ctrl_state = 0`.
- **TX path.**
  - 4 AHB writes of 0xA0–0xA3 -> 4 `store_tx_data` pulses, `tx_data` matches each byte.
  - `tx_start` -> `tx_data_ready = 1`.
  - 4 `usb_rd_req` -> 4 `get_tx_packet_data` pulses, then `IDLE` and `tx_data_ready = 0`.
- **RX overrun.** Stream 65 `usb_wr_req` bytes -> 64 acks; the 65th gets no ack and sets `overrun = 1`.
- **RX error.** 10 bytes, then `usb_rx_error` together with `usb_wr_req` -> `flush` pulses, no ack, `ctrl_state = IDLE`.
- **Conflict.** In `RX_READ`, `ahb_wr_req` -> no ack, `conflict = 1`. A following `ahb_clear_req` -> `clear` pulses and both flags return to 0.
- **Same-cycle arbitration.** `ahb_wr_req` and `usb_wr_req` in the same cycle from `IDLE` -> only `usb_wr_ack`, then state `RX_RECV`.
